// File: rtl/salamander_pkg.sv
//==============================================================================
// Module      : salamander_pkg
// Description : Shared types and constants for the salamander sequencer.
//               Holds the FSM state encoding, the opcode set, the PC and
//               instruction widths, and small opcode-classification helpers
//               used by both the sequencer and its instruction register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package salamander_pkg;

  // Program counter width; the PC instance is built with this value.
  localparam int PC_SIZE    = 5;
  // Instruction width: [5:3] opcode, [2:1] register address, [0] carry-in enable.
  localparam int INSTR_SIZE = 6;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    DECODE     = 3'd2,
    EXEC       = 3'd3,
    WRITE_BACK = 3'd4,
    HALT       = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_LD  = 3'b101,
    OP_ST  = 3'b110,
    OP_HLT = 3'b111
  } opcode_t;

  // Opcodes that drive the ALU in EXEC and load the accumulator in WRITE_BACK.
  function automatic logic is_alu_op(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_LD);
  endfunction

  // Arithmetic opcodes: consume a carry-in and update the carry flag.
  function automatic logic is_arith_op(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage : salamander_pkg

`default_nettype wire

// File: rtl/cpu_seq_ctrl_instr_reg.sv
//==============================================================================
// Module      : instr_reg
// Description : Instruction register plus carry flag for the sequencer.
//               The instruction loads on i_load; the carry flag loads i_carry
//               on i_carry_upd and otherwise holds. Both clear on reset.
// Ports       : clk, rstn          - clock, async active-low reset
//               i_load, i_instr    - instruction load enable and data
//               i_carry_upd        - carry flag update enable
//               i_carry            - new carry value (ALU carry out)
//               o_instr            - registered instruction
//               o_carry_flag       - registered carry flag
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_reg
  import salamander_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_load,
  input  logic [INSTR_SIZE-1:0] i_instr,
  input  logic                  i_carry_upd,
  input  logic                  i_carry,
  output logic [INSTR_SIZE-1:0] o_instr,
  output logic                  o_carry_flag
);

  logic [INSTR_SIZE-1:0] r_instr;
  logic                  r_carry_flag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_instr      <= '0;
      r_carry_flag <= 1'b0;
    end else begin
      if (i_load) begin
        r_instr <= i_instr;
      end
      if (i_carry_upd) begin
        r_carry_flag <= i_carry;
      end
    end
  end

  assign o_instr      = r_instr;
  assign o_carry_flag = r_carry_flag;

endmodule : instr_reg

`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
//==============================================================================
// Module      : cpu_seq_ctrl
// Description : Four-cycle instruction sequencer
//               (FETCH -> DECODE -> EXEC -> WRITE_BACK) for the salamander
//               accumulator CPU. Emits single-cycle ALU, accumulator,
//               register-file and PC strobes, and stops in a sticky HALT on
//               an HLT opcode or after the last program address.
// Ports       : clk, rstn              - clock, async active-low reset
//               start_i                - run request, sampled in IDLE only
//               instr_i                - program memory data (valid in DECODE)
//               max_size_reached_i     - PC is at its last address
//               carry_i                - ALU carry out (sampled in WRITE_BACK)
//               pc_inc_o               - PC increment strobe (WRITE_BACK)
//               op_code_o, rf_addr_o   - fields of the instruction register
//               alu_en_o, carry_in_o   - ALU enable / carry-in (EXEC)
//               acc_ce_o, rf_we_o      - accumulator / register-file write
//               carry_flag_o           - stored carry flag
//               state_o, busy_o, halted_o - status
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_seq_ctrl #(
  parameter int PC_SIZE    = 5,
  parameter int INSTR_SIZE = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [INSTR_SIZE-1:0] instr_i,
  input  logic                  max_size_reached_i,
  input  logic                  carry_i,
  output logic                  pc_inc_o,
  output logic [2:0]            op_code_o,
  output logic [1:0]            rf_addr_o,
  output logic                  alu_en_o,
  output logic                  carry_in_o,
  output logic                  acc_ce_o,
  output logic                  rf_we_o,
  output logic                  carry_flag_o,
  output logic [2:0]            state_o,
  output logic                  busy_o,
  output logic                  halted_o
);

  import salamander_pkg::*;

  // The sequencer is built around a fixed 6-bit instruction format and a PC
  // sized by the package; reject any other configuration at elaboration.
  if ((INSTR_SIZE != salamander_pkg::INSTR_SIZE) ||
      (PC_SIZE    != salamander_pkg::PC_SIZE)) begin : g_cfg_check
    $error("cpu_seq_ctrl: PC_SIZE/INSTR_SIZE must match salamander_pkg");
  end

  //--------------------------------------------------------------------------
  // Registers
  //--------------------------------------------------------------------------
  state_t r_state;
  logic   r_busy;
  logic   r_halted;
  logic   r_pc_inc;
  logic   r_alu_en;
  logic   r_cin_en;
  logic   r_acc_ce;
  logic   r_rf_we;

  //--------------------------------------------------------------------------
  // Wires
  //--------------------------------------------------------------------------
  logic [INSTR_SIZE-1:0] w_instr;
  logic                  w_carry_flag;
  opcode_t               w_op;        // opcode held in the instruction register
  opcode_t               w_dec_op;    // opcode arriving on instr_i during DECODE
  logic                  w_ir_load;
  logic                  w_carry_upd;

  assign w_op     = opcode_t'(w_instr[5:3]);
  assign w_dec_op = opcode_t'(instr_i[5:3]);

  // Memory data is valid in DECODE; capture it on the edge leaving DECODE.
  assign w_ir_load   = (r_state == DECODE);
  // Only ADD/SUB move the carry flag, on the edge leaving WRITE_BACK.
  assign w_carry_upd = (r_state == WRITE_BACK) && is_arith_op(w_op);

  instr_reg u_instr_reg (
    .clk          (clk),
    .rstn         (rstn),
    .i_load       (w_ir_load),
    .i_instr      (instr_i),
    .i_carry_upd  (w_carry_upd),
    .i_carry      (carry_i),
    .o_instr      (w_instr),
    .o_carry_flag (w_carry_flag)
  );

  //--------------------------------------------------------------------------
  // Sequencer FSM. Strobes are registered: each one is computed on the edge
  // that enters the state in which it must be high, so it is a clean
  // one-cycle pulse aligned with that state.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_pc_inc <= 1'b0;
      r_alu_en <= 1'b0;
      r_cin_en <= 1'b0;
      r_acc_ce <= 1'b0;
      r_rf_we  <= 1'b0;
    end else begin
      // Strobes default low; the case below raises at most one cycle's worth.
      r_pc_inc <= 1'b0;
      r_alu_en <= 1'b0;
      r_cin_en <= 1'b0;
      r_acc_ce <= 1'b0;
      r_rf_we  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= FETCH;
            r_busy  <= 1'b1;
          end
        end

        FETCH: begin
          r_state <= DECODE;
        end

        DECODE: begin
          // The instruction register loads on this same edge, so EXEC
          // strobes are decoded straight from the memory data.
          r_state  <= EXEC;
          r_alu_en <= is_alu_op(w_dec_op);
          r_cin_en <= is_arith_op(w_dec_op);
        end

        EXEC: begin
          r_state  <= WRITE_BACK;
          r_acc_ce <= is_alu_op(w_op);
          r_rf_we  <= (w_op == OP_ST);
          r_pc_inc <= (w_op != OP_HLT);
        end

        WRITE_BACK: begin
          // Reaching the last address ends the program; the PC never wraps.
          if ((w_op == OP_HLT) || max_size_reached_i) begin
            r_state  <= HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_state <= FETCH;
          end
        end

        HALT: begin
          r_state <= HALT;
        end

        default: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign state_o      = r_state;
  assign busy_o       = r_busy;
  assign halted_o     = r_halted;
  assign pc_inc_o     = r_pc_inc;
  assign alu_en_o     = r_alu_en;
  assign acc_ce_o     = r_acc_ce;
  assign rf_we_o      = r_rf_we;
  assign op_code_o    = w_instr[5:3];
  assign rf_addr_o    = w_instr[2:1];
  assign carry_flag_o = w_carry_flag;
  // r_cin_en marks EXEC of ADD/SUB; the flag cannot change until WRITE_BACK
  // ends, so gating with the stored flag and enable bit is stable here.
  assign carry_in_o   = r_cin_en & w_instr[0] & w_carry_flag;

endmodule : cpu_seq_ctrl

`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
//==============================================================================
// Module      : tb_cpu_seq_ctrl
// Description : Directed, table-driven bench for cpu_seq_ctrl. Each table row
//               gives the inputs for one clock cycle and the full output word
//               expected just after that edge. Hand-written sequences cover
//               HLT, HALT stickiness and asynchronous reset mid-instruction.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start_i = 1'b0;
  logic [5:0] instr_i = '0;
  logic       max_size_reached_i = 1'b0;
  logic       carry_i = 1'b0;
  logic       pc_inc_o, alu_en_o, carry_in_o, acc_ce_o, rf_we_o;
  logic       carry_flag_o, busy_o, halted_o;
  logic [2:0] op_code_o, state_o;
  logic [1:0] rf_addr_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.PC_SIZE(5), .INSTR_SIZE(6)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .start_i            (start_i),
    .instr_i            (instr_i),
    .max_size_reached_i (max_size_reached_i),
    .carry_i            (carry_i),
    .pc_inc_o           (pc_inc_o),
    .op_code_o          (op_code_o),
    .rf_addr_o          (rf_addr_o),
    .alu_en_o           (alu_en_o),
    .carry_in_o         (carry_in_o),
    .acc_ce_o           (acc_ce_o),
    .rf_we_o            (rf_we_o),
    .carry_flag_o       (carry_flag_o),
    .state_o            (state_o),
    .busy_o             (busy_o),
    .halted_o           (halted_o)
  );

  // Output word: {state, busy, halted, pc_inc, alu_en, carry_in, acc_ce,
  //               rf_we, carry_flag, op_code, rf_addr}
  logic [15:0] act;
  assign act = {state_o, busy_o, halted_o, pc_inc_o, alu_en_o, carry_in_o,
                acc_ce_o, rf_we_o, carry_flag_o, op_code_o, rf_addr_o};

  function automatic logic [15:0] E(input logic [2:0] st, input logic pc,
                                    input logic alu, input logic cin,
                                    input logic acc, input logic we,
                                    input logic cf, input logic [2:0] op,
                                    input logic [1:0] rf);
    logic busy, halted;
    busy   = (st >= 3'd1) && (st <= 3'd4);
    halted = (st == 3'd5);
    return {st, busy, halted, pc, alu, cin, acc, we, cf, op, rf};
  endfunction

  typedef struct {
    logic        start;
    logic [5:0]  instr;
    logic        maxr;
    logic        carry;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic [5:0] ins, input logic m,
                     input logic c, input logic [15:0] e);
    vec_t v;
    v.start = s; v.instr = ins; v.maxr = m; v.carry = c; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, clock once, then compare away from the edge.
  task automatic step(input string name, input logic s, input logic [5:0] ins,
                      input logic m, input logic c, input logic [15:0] e);
    start_i = s; instr_i = ins; max_size_reached_i = m; carry_i = c;
    @(posedge clk);
    #1;
    check(name, e);
  endtask

  task automatic do_reset();
    start_i = 1'b0; instr_i = '0; max_size_reached_i = 1'b0; carry_i = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", 16'h0000);
    rstn = 1'b1;
  endtask

  initial begin
    // Main program: ADD r1, AND (bit0 set), SUB r2 +c, ST r3, LD r1, NOP at last addr.
    add(0, 6'b000000, 0, 0, E(0, 0,0,0,0,0, 0, 3'd0, 2'd0));
    add(1, 6'b000000, 0, 0, E(1, 0,0,0,0,0, 0, 3'd0, 2'd0));
    add(0, 6'b000000, 0, 0, E(2, 0,0,0,0,0, 0, 3'd0, 2'd0));
    add(0, 6'b001010, 0, 0, E(3, 0,1,0,0,0, 0, 3'd1, 2'd1));
    add(0, 6'b000000, 0, 0, E(4, 1,0,0,1,0, 0, 3'd1, 2'd1));
    add(0, 6'b000000, 0, 1, E(1, 0,0,0,0,0, 1, 3'd1, 2'd1));
    add(0, 6'b000000, 0, 0, E(2, 0,0,0,0,0, 1, 3'd1, 2'd1));
    add(0, 6'b011001, 0, 0, E(3, 0,1,0,0,0, 1, 3'd3, 2'd0));
    add(0, 6'b000000, 0, 0, E(4, 1,0,0,1,0, 1, 3'd3, 2'd0));
    add(0, 6'b000000, 0, 0, E(1, 0,0,0,0,0, 1, 3'd3, 2'd0));
    add(0, 6'b000000, 0, 0, E(2, 0,0,0,0,0, 1, 3'd3, 2'd0));
    add(0, 6'b010101, 0, 0, E(3, 0,1,1,0,0, 1, 3'd2, 2'd2));
    add(0, 6'b000000, 0, 0, E(4, 1,0,0,1,0, 1, 3'd2, 2'd2));
    add(0, 6'b000000, 0, 0, E(1, 0,0,0,0,0, 0, 3'd2, 2'd2));
    add(1, 6'b000000, 0, 0, E(2, 0,0,0,0,0, 0, 3'd2, 2'd2));
    add(0, 6'b110110, 0, 0, E(3, 0,0,0,0,0, 0, 3'd6, 2'd3));
    add(0, 6'b000000, 0, 0, E(4, 1,0,0,0,1, 0, 3'd6, 2'd3));
    add(0, 6'b000000, 0, 1, E(1, 0,0,0,0,0, 0, 3'd6, 2'd3));
    add(0, 6'b000000, 0, 0, E(2, 0,0,0,0,0, 0, 3'd6, 2'd3));
    add(0, 6'b101011, 0, 0, E(3, 0,1,0,0,0, 0, 3'd5, 2'd1));
    add(0, 6'b000000, 0, 0, E(4, 1,0,0,1,0, 0, 3'd5, 2'd1));
    add(0, 6'b000000, 0, 1, E(1, 0,0,0,0,0, 0, 3'd5, 2'd1));
    add(0, 6'b000000, 0, 0, E(2, 0,0,0,0,0, 0, 3'd5, 2'd1));
    add(0, 6'b000000, 0, 0, E(3, 0,0,0,0,0, 0, 3'd0, 2'd0));
    add(0, 6'b000000, 0, 0, E(4, 1,0,0,0,0, 0, 3'd0, 2'd0));
    add(0, 6'b000000, 1, 0, E(5, 0,0,0,0,0, 0, 3'd0, 2'd0));
    add(1, 6'b000000, 0, 0, E(5, 0,0,0,0,0, 0, 3'd0, 2'd0));
    add(0, 6'b000000, 0, 0, E(5, 0,0,0,0,0, 0, 3'd0, 2'd0));

    do_reset();
    foreach (tbl[i]) begin
      step($sformatf("prog_row%0d", i), tbl[i].start, tbl[i].instr,
           tbl[i].maxr, tbl[i].carry, tbl[i].exp);
    end

    // HLT: no pc_inc, HALT after WRITE_BACK, start pulses ignored.
    do_reset();
    step("hlt_fetch",  1, 6'b000000, 0, 0, E(1, 0,0,0,0,0, 0, 3'd0, 2'd0));
    step("hlt_decode", 0, 6'b000000, 0, 0, E(2, 0,0,0,0,0, 0, 3'd0, 2'd0));
    step("hlt_exec",   0, 6'b111000, 0, 0, E(3, 0,0,0,0,0, 0, 3'd7, 2'd0));
    step("hlt_wb",     0, 6'b000000, 0, 1, E(4, 0,0,0,0,0, 0, 3'd7, 2'd0));
    step("hlt_halt",   0, 6'b000000, 0, 1, E(5, 0,0,0,0,0, 0, 3'd7, 2'd0));
    for (int k = 0; k < 3; k++) begin
      step($sformatf("hlt_sticky%0d", k), 1, 6'b000000, 0, 0,
           E(5, 0,0,0,0,0, 0, 3'd7, 2'd0));
    end

    // Asynchronous reset during EXEC of an ADD.
    do_reset();
    step("rst_fetch",  1, 6'b000000, 0, 0, E(1, 0,0,0,0,0, 0, 3'd0, 2'd0));
    step("rst_decode", 0, 6'b000000, 0, 0, E(2, 0,0,0,0,0, 0, 3'd0, 2'd0));
    step("rst_exec",   0, 6'b001011, 0, 0, E(3, 0,1,0,0,0, 0, 3'd1, 2'd1));
    #2;
    rstn = 1'b0;
    #1;
    check("rst_async", 16'h0000);
    @(posedge clk);
    #1;
    check("rst_held", 16'h0000);
    rstn = 1'b1;
    step("rst_idle",   0, 6'b000000, 0, 0, E(0, 0,0,0,0,0, 0, 3'd0, 2'd0));
    step("rst_idle2",  0, 6'b000000, 0, 0, E(0, 0,0,0,0,0, 0, 3'd0, 2'd0));
    step("rst_restart",1, 6'b000000, 0, 0, E(1, 0,0,0,0,0, 0, 3'd0, 2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_cpu_seq_ctrl

`default_nettype wire
